// File: rtl/booth_datapath_if.sv
// Command/status bundle between the Booth control FSM (master) and the
// register/arithmetic datapath (slave).
interface booth_datapath_if #(
  parameter int N = 4
);
  logic [N-1:0]   mIn;
  logic [N-1:0]   qIn;
  logic           mSignal;
  logic           addSubSignal;
  logic [1:0]     aSignal;
  logic [1:0]     qSignal;
  logic           finished;
  logic [N-1:0]   qReg;
  logic           qNeg;
  logic [N-1:0]   aReg;
  logic [2*N-1:0] product;
  logic           productValid;

  modport master (
    output mIn, qIn, mSignal, addSubSignal, aSignal, qSignal, finished,
    input  qReg, qNeg, aReg, product, productValid
  );

  modport slave (
    input  mIn, qIn, mSignal, addSubSignal, aSignal, qSignal, finished,
    output qReg, qNeg, aReg, product, productValid
  );
endinterface

// File: rtl/booth_datapath.sv
// Booth multiplier datapath: M/A/Q/Q-1 registers, N-bit add/sub, and a
// product capture on the rising edge of the control's finished level.
module booth_datapath #(
  parameter int N = 4  // must match the N of the connected interface
) (
  input  logic              clk,
  input  logic              rst,
  booth_datapath_if.slave   dp_if
);

  typedef enum logic [1:0] {
    A_HOLD  = 2'b00,
    A_CLEAR = 2'b01,
    A_SUM   = 2'b10,
    A_ASR   = 2'b11
  } a_cmd_e;

  typedef enum logic [1:0] {
    Q_HOLD  = 2'b00,
    Q_LOAD  = 2'b01,
    Q_SHIFT = 2'b10,
    Q_CLEAR = 2'b11
  } q_cmd_e;

  logic [N-1:0]   m_q, m_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   q_q, q_d;
  logic           qneg_q, qneg_d;
  logic           fin_prev_q;
  logic [2*N-1:0] product_q, product_d;
  logic           pvalid_q, pvalid_d;
  logic [N-1:0]   sum;

  // Modulo-2^N result; overflow (e.g. M = -2^(N-1)) is intentionally dropped.
  assign sum = dp_if.addSubSignal ? (a_q - m_q) : (a_q + m_q);

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    qneg_d    = qneg_q;
    product_d = product_q;
    pvalid_d  = 1'b0;

    if (dp_if.mSignal) m_d = dp_if.mIn;

    case (a_cmd_e'(dp_if.aSignal))
      A_HOLD:  a_d = a_q;
      A_CLEAR: a_d = '0;
      A_SUM:   a_d = sum;
      A_ASR:   a_d = {a_q[N-1], a_q[N-1:1]};
      default: a_d = a_q;
    endcase

    // Shift takes the pre-edge A[0], independent of the A command.
    case (q_cmd_e'(dp_if.qSignal))
      Q_HOLD:  ;
      Q_LOAD:  begin q_d = dp_if.qIn;            qneg_d = 1'b0;   end
      Q_SHIFT: begin q_d = {a_q[0], q_q[N-1:1]}; qneg_d = q_q[0]; end
      Q_CLEAR: begin q_d = '0;                   qneg_d = 1'b0;   end
      default: ;
    endcase

    if (dp_if.finished && !fin_prev_q) begin
      product_d = {a_q, q_q};
      pvalid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      m_q        <= '0;
      a_q        <= '0;
      q_q        <= '0;
      qneg_q     <= 1'b0;
      fin_prev_q <= 1'b0;
      product_q  <= '0;
      pvalid_q   <= 1'b0;
    end else begin
      m_q        <= m_d;
      a_q        <= a_d;
      q_q        <= q_d;
      qneg_q     <= qneg_d;
      fin_prev_q <= dp_if.finished;
      product_q  <= product_d;
      pvalid_q   <= pvalid_d;
    end
  end

  assign dp_if.qReg         = q_q;
  assign dp_if.qNeg         = qneg_q;
  assign dp_if.aReg         = a_q;
  assign dp_if.product      = product_q;
  assign dp_if.productValid = pvalid_q;

endmodule
